// File: rtl/moore_seq_detector_param_if.sv
// Bus bundle between the serial pattern detector and its driver.
// It carries the runtime configuration, the serial bit stream and the detector status.
interface moore_seq_detector_param_if #(
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(PAT_MAX + 1);

  logic               en;
  logic [PAT_MAX-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               bit_in;
  logic               bit_valid;
  logic               count_clr;
  logic               detect;
  logic [CNT_W-1:0]   match_count;
  logic [1:0]         state_out;
  logic               cfg_err;

  modport master (
    output en, cfg_pattern, cfg_len, cfg_overlap, bit_in, bit_valid, count_clr,
    input  detect, match_count, state_out, cfg_err
  );

  modport slave (
    input  en, cfg_pattern, cfg_len, cfg_overlap, bit_in, bit_valid, count_clr,
    output detect, match_count, state_out, cfg_err
  );
endinterface

// File: rtl/moore_seq_detector_param.sv
// Programmable serial Moore pattern detector with a saturating match counter.
// A bit accepted in cycle N raises detect in cycle N+1; bit_valid=0 simply stalls the history.
module moore_seq_detector_param #(
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8
) (
  input logic                        clk,
  input logic                        rst,
  moore_seq_detector_param_if.slave  bus
);
  localparam int LEN_W = $clog2(PAT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HIT  = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_MAX-1:0] hist_q, hist_d;
  logic [PAT_MAX-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PAT_MAX-1:0] hist_nx;
  logic [PAT_MAX-1:0] len_mask;
  logic [LEN_W:0]     fill_p1;
  logic [LEN_W-1:0]   fill_sat;
  logic               cfg_legal;
  logic               match;

  always_comb begin
    hist_nx   = {hist_q[PAT_MAX-2:0], bus.bit_in};
    fill_p1   = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
    for (int i = 0; i < PAT_MAX; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    fill_sat  = (fill_p1 >= {1'b0, len_q}) ? len_q : fill_p1[LEN_W-1:0];
    // Both the fill check and the pattern check look at the post-shift history.
    match     = bus.bit_valid && (fill_p1 >= {1'b0, len_q}) &&
                (((hist_nx ^ pat_q) & len_mask) == '0);
    cfg_legal = (bus.cfg_len != '0) && ({1'b0, bus.cfg_len} <= (LEN_W+1)'(PAT_MAX));

    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        err_d = bus.en && !cfg_legal;
        if (bus.en && cfg_legal) begin
          pat_d   = bus.cfg_pattern;
          len_d   = bus.cfg_len;
          ovl_d   = bus.cfg_overlap;
          hist_d  = '0;
          fill_d  = '0;
          state_d = RUN;
        end
      end
      RUN, HIT: begin
        if (!bus.en) begin
          state_d = IDLE;
          hist_d  = '0;
          fill_d  = '0;
        end else if (bus.bit_valid) begin
          hist_d = hist_nx;
          if (match) begin
            state_d = HIT;
            fill_d  = ovl_q ? len_q : '0;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          end else begin
            state_d = RUN;
            fill_d  = fill_sat;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.count_clr) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.detect      = (state_q == HIT);
  assign bus.match_count = cnt_q;
  assign bus.state_out   = state_q;
  assign bus.cfg_err     = err_q;
endmodule
